array_output_drain: RTL and testbench

- Consumer end of the systolic-array output buffer's single read port.
- Pops 32-bit accumulator entries tagged (row, col) using the valid/consume handshake.
- Requantizes each entry to int8 and packs four bytes per 32-bit word.
- Issues byte-strobed word writes to output activation memory, with valid/ready backpressure.

---
 rtl/array_output_drain_pkg.sv | 24 ++
 rtl/array_output_drain_requant_unit.sv | 66 ++++++
 rtl/array_output_drain.sv | 154 +++++++++++++++
 tb/tb_array_output_drain.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_output_drain_pkg.sv
// array_output_drain_pkg: shared sizing, requant config type and int8 saturation.
// Revision 1.0
`default_nettype none

package array_output_drain_pkg;

  localparam int MAX_N  = 16;
  localparam int N_BITS = $clog2(MAX_N);

  typedef struct packed {
    logic signed [31:0] mult;
    logic        [5:0]  shift;
    logic signed [7:0]  zp;
  } requant_cfg_t;

  function automatic logic [7:0] sat_int8(input logic signed [65:0] v);
    if (v > 66'sd127)       return 8'h7F;
    else if (v < -66'sd128) return 8'h80;
    else                    return v[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/array_output_drain_requant_unit.sv
// requant_unit: two-stage int32 -> int8 requantizer (multiply, round-shift, zero point, saturate).
// Revision 1.0
`default_nettype none

module requant_unit
  import array_output_drain_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  requant_cfg_t       cfg,
  input  logic               in_valid,
  input  logic signed [31:0] in_acc,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  output logic [7:0]         out_byte,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  logic               s2_valid;
  logic signed [63:0] s2_prod;
  logic [TAG_W-1:0]   s2_tag;
  logic signed [63:0] acc_ext;
  logic signed [63:0] mult_ext;
  logic signed [64:0] half;
  logic signed [64:0] rnd_sum;
  logic signed [64:0] rnd;
  logic signed [65:0] with_zp;

  assign acc_ext  = {{32{in_acc[31]}}, in_acc};
  assign mult_ext = {{32{cfg.mult[31]}}, cfg.mult};
  assign busy     = s2_valid || out_valid;

  // One extra bit of headroom: 2^62 product plus a 2^62 rounding term must not wrap.
  always_comb begin
    half    = 65'sd1 <<< (cfg.shift - 6'd1);
    rnd_sum = {s2_prod[63], s2_prod};
    if (cfg.shift != 6'd0) rnd_sum = rnd_sum + half;
    rnd     = rnd_sum >>> cfg.shift;
    with_zp = {rnd[64], rnd} + {{58{cfg.zp[7]}}, cfg.zp};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid  <= 1'b0;
      s2_prod   <= '0;
      s2_tag    <= '0;
      out_valid <= 1'b0;
      out_byte  <= '0;
      out_tag   <= '0;
    end else if (en) begin
      s2_valid  <= in_valid;
      s2_prod   <= acc_ext * mult_ext;
      s2_tag    <= in_tag;
      out_valid <= s2_valid;
      out_byte  <= sat_int8(with_zp);
      out_tag   <= s2_tag;
    end
  end

endmodule

`default_nettype wire

// File: rtl/array_output_drain.sv
// array_output_drain: pops tagged accumulators, requantizes to int8 and writes packed words.
// Revision 1.0
`default_nettype none

module array_output_drain #(
  parameter int MAX_N  = 16,
  parameter int N_BITS = $clog2(MAX_N),
  parameter int ADDR_W = 2 * N_BITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [31:0] in_output,
  input  logic [N_BITS-1:0]  in_row,
  input  logic [N_BITS-1:0]  in_col,
  output logic               in_consume,
  input  logic signed [31:0] cfg_mult,
  input  logic [5:0]         cfg_shift,
  input  logic signed [7:0]  cfg_zp,
  input  logic [N_BITS:0]    cfg_n,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic               flush,
  output logic               flush_done,
  output logic               mem_wr_en,
  output logic [ADDR_W-1:0]  mem_wr_addr,
  output logic [31:0]        mem_wr_data,
  output logic [3:0]         mem_wr_strb,
  input  logic               mem_ready,
  output logic               idle
);
  import array_output_drain_pkg::*;

  logic               adv, drained, flush_pending, flush_complete;
  logic               s1_valid, s3_valid, rq_busy;
  logic signed [31:0] s1_acc;
  logic [N_BITS-1:0]  s1_row, s1_col;
  logic [ADDR_W-1:0]  s1_b, s3_b, s3_word;
  logic [1:0]         s3_lane;
  logic [7:0]         s3_byte;
  requant_cfg_t       cfg;

  logic               pack_valid, pack_valid_nx;
  logic [ADDR_W-1:0]  pack_addr, pack_addr_nx, emit_addr;
  logic [31:0]        pack_data, pack_data_nx, merged_data, emit_data;
  logic [3:0]         pack_strb, pack_strb_nx, merged_strb, emit_strb;
  logic               emit;

  assign adv        = !(mem_wr_en && !mem_ready);
  assign in_consume = in_valid && adv && !flush_pending;
  assign cfg        = '{mult: cfg_mult, shift: cfg_shift, zp: cfg_zp};
  assign s1_b       = ADDR_W'(s1_row) * ADDR_W'(cfg_n) + ADDR_W'(s1_col);
  assign s3_word    = cfg_base + (s3_b >> 2);
  assign s3_lane    = s3_b[1:0];
  assign drained    = !s1_valid && !rq_busy;
  assign idle       = drained && !pack_valid && !mem_wr_en && !flush_pending;
  // Flush ends when nothing is left upstream and the port is empty or handing off its last word.
  assign flush_complete = flush_pending && drained && !pack_valid && (!mem_wr_en || mem_ready);

  requant_unit #(.TAG_W(ADDR_W)) u_requant (
    .clk       (clk),
    .reset     (reset),
    .en        (adv),
    .cfg       (cfg),
    .in_valid  (s1_valid),
    .in_acc    (s1_acc),
    .in_tag    (s1_b),
    .out_valid (s3_valid),
    .out_byte  (s3_byte),
    .out_tag   (s3_b),
    .busy      (rq_busy)
  );

  always_comb begin
    emit          = 1'b0;
    emit_addr     = pack_addr;
    emit_data     = pack_data;
    emit_strb     = pack_strb;
    pack_valid_nx = pack_valid;
    pack_addr_nx  = pack_addr;
    pack_data_nx  = pack_data;
    pack_strb_nx  = pack_strb;
    merged_data   = pack_data;
    merged_data[8*s3_lane +: 8] = s3_byte;
    merged_strb   = pack_strb | (4'b0001 << s3_lane);
    if (adv && s3_valid) begin
      if (pack_valid && pack_addr == s3_word) begin
        if (merged_strb == 4'hF) begin
          emit          = 1'b1;
          emit_data     = merged_data;
          emit_strb     = 4'hF;
          pack_valid_nx = 1'b0;
        end else begin
          pack_data_nx = merged_data;
          pack_strb_nx = merged_strb;
        end
      end else begin
        emit          = pack_valid;
        pack_valid_nx = 1'b1;
        pack_addr_nx  = s3_word;
        pack_data_nx  = {24'd0, s3_byte} << (8 * s3_lane);
        pack_strb_nx  = 4'b0001 << s3_lane;
      end
    end else if (adv && flush_pending && drained && pack_valid) begin
      emit          = 1'b1;
      pack_valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid      <= 1'b0;
      s1_acc        <= '0;
      s1_row        <= '0;
      s1_col        <= '0;
      pack_valid    <= 1'b0;
      pack_addr     <= '0;
      pack_data     <= '0;
      pack_strb     <= '0;
      mem_wr_en     <= 1'b0;
      mem_wr_addr   <= '0;
      mem_wr_data   <= '0;
      mem_wr_strb   <= '0;
      flush_pending <= 1'b0;
      flush_done    <= 1'b0;
    end else begin
      if (adv) begin
        s1_valid   <= in_consume;
        if (in_consume) begin
          s1_acc <= in_output;
          s1_row <= in_row;
          s1_col <= in_col;
        end
        pack_valid <= pack_valid_nx;
        pack_addr  <= pack_addr_nx;
        pack_data  <= pack_data_nx;
        pack_strb  <= pack_strb_nx;
        mem_wr_en  <= emit;
        if (emit) begin
          mem_wr_addr <= emit_addr;
          mem_wr_data <= emit_data;
          mem_wr_strb <= emit_strb;
        end else begin
          mem_wr_strb <= 4'h0;
        end
      end
      flush_done <= flush_complete;
      if (flush_complete) flush_pending <= 1'b0;
      else if (flush)     flush_pending <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_array_output_drain.sv
// tb_array_output_drain: directed vectors with a scoreboard-checked write port.
// Revision 1.0
`default_nettype none

module tb_array_output_drain;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [31:0] in_output;
  logic [3:0]         in_row, in_col;
  logic               in_consume;
  logic signed [31:0] cfg_mult;
  logic [5:0]         cfg_shift;
  logic signed [7:0]  cfg_zp;
  logic [4:0]         cfg_n;
  logic [7:0]         cfg_base;
  logic               flush, flush_done;
  logic               mem_wr_en, mem_ready, idle;
  logic [7:0]         mem_wr_addr;
  logic [31:0]        mem_wr_data;
  logic [3:0]         mem_wr_strb;

  always #5 clk = ~clk;

  array_output_drain dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_output(in_output), .in_row(in_row), .in_col(in_col),
    .in_consume(in_consume),
    .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp), .cfg_n(cfg_n),
    .cfg_base(cfg_base),
    .flush(flush), .flush_done(flush_done),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_strb(mem_wr_strb), .mem_ready(mem_ready), .idle(idle)
  );

  typedef struct packed {logic [7:0] addr; logic [31:0] data; logic [3:0] strb;} wr_t;
  typedef struct packed {logic [31:0] val; logic [3:0] row; logic [3:0] col;} ent_t;

  wr_t  exp_q[$];
  ent_t src_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_wr_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int r, input int c, input int v);
    ent_t e;
    e.val = v;
    e.row = r[3:0];
    e.col = c[3:0];
    src_q.push_back(e);
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.strb = s;
    exp_q.push_back(w);
  endtask

  task automatic set_cfg(input int m, input int sh, input int zp, input int n, input int base);
    cfg_mult  = m;
    cfg_shift = sh[5:0];
    cfg_zp    = zp[7:0];
    cfg_n     = n[4:0];
    cfg_base  = base[7:0];
  endtask

  task automatic wait_consume(output int at);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin @(negedge clk); ok = in_consume; end
    at = cyc;
    chk("wait_consume_timeout", ok, 1'b1);
  endtask

  task automatic wait_wr(output int at);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin @(negedge clk); ok = mem_wr_en; end
    at = cyc;
    chk("wait_write_timeout", ok, 1'b1);
  endtask

  task automatic wait_src_empty();
    bit ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = (src_q.size() == 0) && !in_valid;
    end
    chk("wait_source_empty_timeout", ok, 1'b1);
    tick(1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = idle && (src_q.size() == 0) && !in_valid;
    end
    chk("wait_idle_timeout", ok, 1'b1);
    tick(1);
  endtask

  task automatic do_flush(input bit with_write);
    int f;
    bit ok = 1'b0;
    flush = 1'b1;
    f = cyc;
    tick(1);
    flush = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); ok = flush_done; end
    chk("flush_done_seen", ok, 1'b1);
    if (with_write) chk("flush_done_after_write", cyc - last_wr_cyc, 1);
    else            chk("flush_done_nothing_to_emit", cyc - f, 2);
    @(negedge clk);
    chk("flush_done_single_pulse", flush_done, 1'b0);
    tick(1);
  endtask

  // Buffer model: presents the queue head and drops it once the DUT pops it.
  initial begin : source
    bit popped;
    in_valid  = 1'b0;
    in_output = '0;
    in_row    = '0;
    in_col    = '0;
    forever begin
      @(negedge clk);
      popped = in_valid && in_consume && reset;
      @(posedge clk);
      #1;
      if (popped && src_q.size() > 0) void'(src_q.pop_front());
      if (!reset) src_q.delete();
      if (src_q.size() > 0) begin
        in_valid  = 1'b1;
        in_output = src_q[0].val;
        in_row    = src_q[0].row;
        in_col    = src_q[0].col;
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (mem_wr_en && mem_ready) begin
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", mem_wr_en, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", mem_wr_addr, e.addr);
          chk("wr_data", mem_wr_data, e.data);
          chk("wr_strb", mem_wr_strb, e.strb);
        end
      end else if (mem_wr_en && !mem_ready) begin
        chk("consume_during_stall", in_consume, 1'b0);
        if (exp_q.size() > 0) begin
          chk("stall_hold_addr", mem_wr_addr, exp_q[0].addr);
          chk("stall_hold_data", mem_wr_data, exp_q[0].data);
          chk("stall_hold_strb", mem_wr_strb, exp_q[0].strb);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t0, tw;
    reset     = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b1;
    set_cfg(1, 0, 0, 4, 'h10);
    tick(3);

    chk("reset_wr_en", mem_wr_en, 1'b0);
    chk("reset_wr_strb", mem_wr_strb, 4'h0);
    chk("reset_wr_addr", mem_wr_addr, 8'h00);
    chk("reset_wr_data", mem_wr_data, 32'h0);
    chk("reset_flush_done", flush_done, 1'b0);
    chk("reset_idle", idle, 1'b1);
    #2 reset = 1'b1;
    tick(2);

    // 1: full word, latency from last pop to write is 4 cycles
    expect_wr(8'h10, 32'h04030201, 4'hF);
    for (int c = 0; c < 4; c++) push(0, c, c + 1);
    wait_consume(t0);
    wait_wr(tw);
    chk("t1_write_latency", tw - t0, 7);
    wait_idle();

    // 2: rounding, zero point and saturation in every lane
    set_cfg(3, 2, -5, 4, 'h00);
    expect_wr(8'h00, 32'hF6807FFF, 4'hF);
    push(0, 0, 5);
    push(0, 1, 1000);
    push(0, 2, -1000);
    push(0, 3, -7);
    wait_idle();

    // 3: word change emits the earlier partial word; new byte stays packed
    set_cfg(1, 0, 0, 8, 'h40);
    expect_wr(8'h40, 32'h00001100, 4'b0010);
    push(0, 1, 'h11);
    push(1, 0, 'h22);
    wait_src_empty();
    tick(8);
    chk("t3_first_word_written", exp_q.size(), 0);
    chk("t3_second_held_no_write", mem_wr_en, 1'b0);
    chk("t3_second_held_not_idle", idle, 1'b0);

    // 4: flush drains the partial pack, then a flush with nothing to emit
    expect_wr(8'h42, 32'h00000022, 4'b0001);
    do_flush(1'b1);
    wait_idle();
    do_flush(1'b0);
    chk("t4_idle_after_empty_flush", idle, 1'b1);

    // 5: backpressure on a 12-element stream
    set_cfg(1, 0, 0, 4, 'h20);
    expect_wr(8'h20, 32'h04030201, 4'hF);
    expect_wr(8'h21, 32'h08070605, 4'hF);
    expect_wr(8'h22, 32'h0C0B0A09, 4'hF);
    mem_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(i / 4, i % 4, i + 1);
    wait_wr(tw);
    tick(5);
    mem_ready = 1'b1;
    wait_idle();
    chk("t5_all_words_written", exp_q.size(), 0);

    // 6: reset with entries in flight discards them
    set_cfg(1, 0, 0, 4, 'h10);
    for (int c = 0; c < 3; c++) push(0, c, 'h50 + c);
    wait_consume(t0);
    tick(3);
    chk("t6_busy_before_reset", idle, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("t6_reset_wr_en", mem_wr_en, 1'b0);
    chk("t6_reset_idle", idle, 1'b1);
    src_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick(1);
    expect_wr(8'h10, 32'h0D0C0B0A, 4'hF);
    for (int c = 0; c < 4; c++) push(0, c, 'h0A + c);
    wait_idle();

    // 7: repeated lane overwrites the earlier byte
    set_cfg(1, 0, 0, 4, 'h30);
    expect_wr(8'h30, 32'h00000009, 4'b0001);
    push(0, 0, 7);
    push(0, 0, 9);
    wait_src_empty();
    do_flush(1'b1);
    wait_idle();

    chk("final_scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
